// File: rtl/jpeg_entropy_bitstream_reader_if.sv
// Bus between the JPEG entropy bitstream reader and its neighbours.
// Byte side:    in_data / in_valid / in_ready.
// Decoder side: peek_bits, bits_avail, consume_n, sync_clear.
// Marker side:  marker_valid, marker_code, marker_is_rst, marker_ack.
// Status:       underflow_err.
// slave = the reader itself; master = the surrounding logic (or a bench).
interface jpeg_entropy_bitstream_reader_if #(
   parameter int unsigned ACC_W  = 32,
   parameter int unsigned PEEK_W = 16
);
   localparam int unsigned CNT_W = $clog2(ACC_W + 1);
   localparam int unsigned CN_W  = $clog2(PEEK_W + 1);

   logic [7:0]        in_data;
   logic              in_valid;
   logic              in_ready;
   logic [PEEK_W-1:0] peek_bits;
   logic [CNT_W-1:0]  bits_avail;
   logic [CN_W-1:0]   consume_n;
   logic              sync_clear;
   logic              marker_valid;
   logic [7:0]        marker_code;
   logic              marker_is_rst;
   logic              marker_ack;
   logic              underflow_err;

   modport slave (
      input  in_data, in_valid, consume_n, sync_clear, marker_ack,
      output in_ready, peek_bits, bits_avail, marker_valid, marker_code,
             marker_is_rst, underflow_err
   );

   modport master (
      output in_data, in_valid, consume_n, sync_clear, marker_ack,
      input  in_ready, peek_bits, bits_avail, marker_valid, marker_code,
             marker_is_rst, underflow_err
   );
endinterface

// File: rtl/jpeg_entropy_bitstream_reader.sv
// JPEG entropy-coded-segment reader: strips 0xFF00 byte stuffing and 0xFF
// fill bytes, detects markers (holding the stream until acknowledged) and
// presents an MSB-first bit window with variable-length consume.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   rd_if      : slave modport carrying the byte input, the peek/consume
//                window, the marker handshake and the sticky underflow flag
module jpeg_entropy_bitstream_reader #(
   parameter int unsigned ACC_W  = 32,
   parameter int unsigned PEEK_W = 16
) (
   input  logic clk,
   input  logic rst_n,
   jpeg_entropy_bitstream_reader_if.slave rd_if
);
   localparam int unsigned CNT_W    = $clog2(ACC_W + 1);
   localparam int unsigned AW       = CNT_W + 1;
   localparam int unsigned FILL_MAX = ACC_W - 8;

   typedef enum logic [1:0] {
      ST_NORMAL = 2'd0,
      ST_SAW_FF = 2'd1,
      ST_HOLD   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rdy_q;
   logic             mvalid_q;
   logic [7:0]       mcode_q;
   logic             mrst_q;
   logic             uerr_q;

   logic             fire_c;
   logic             append_c;
   logic [7:0]       app_byte_c;
   logic             marker_c;
   logic             cons_ok_c;
   logic             underflow_c;
   logic [AW-1:0]    base_c;
   logic [AW-1:0]    cnt_wide_c;
   logic [ACC_W-1:0] kept_c;
   logic [ACC_W-1:0] app_vec_c;

   // Byte-level destuffing decisions and next state
   always_comb begin
      fire_c     = rd_if.in_valid && rdy_q;
      append_c   = 1'b0;
      marker_c   = 1'b0;
      app_byte_c = rd_if.in_data;
      state_d    = state_q;
      case (state_q)
         ST_NORMAL: begin
            if (fire_c) begin
               if (rd_if.in_data == 8'hFF) state_d  = ST_SAW_FF;
               else                        append_c = 1'b1;
            end
         end
         ST_SAW_FF: begin
            if (fire_c) begin
               if (rd_if.in_data == 8'h00) begin
                  append_c   = 1'b1;
                  app_byte_c = 8'hFF;
                  state_d    = ST_NORMAL;
               end else if (rd_if.in_data != 8'hFF) begin
                  marker_c = 1'b1;
                  state_d  = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            if (rd_if.marker_ack) state_d = ST_NORMAL;
         end
         default: state_d = ST_NORMAL;
      endcase
   end

   // Accumulator: drop consumed bits, then place the new byte right after
   // the surviving ones. Counts are widened so an over-consume is seen
   // before truncation.
   always_comb begin
      cons_ok_c   = AW'(rd_if.consume_n) <= AW'(cnt_q);
      underflow_c = !rd_if.sync_clear && !cons_ok_c;
      if (rd_if.sync_clear) begin
         kept_c = '0;
         base_c = '0;
      end else if (cons_ok_c) begin
         kept_c = acc_q << rd_if.consume_n;
         base_c = AW'(cnt_q) - AW'(rd_if.consume_n);
      end else begin
         kept_c = acc_q;
         base_c = AW'(cnt_q);
      end
      app_vec_c = '0;
      if (append_c) app_vec_c[ACC_W-1 -: 8] = app_byte_c;
      app_vec_c  = app_vec_c >> base_c;
      acc_d      = kept_c | app_vec_c;
      cnt_wide_c = base_c + (append_c ? AW'(8) : AW'(0));
      cnt_d      = CNT_W'(cnt_wide_c);
   end

   // State and output registers; in_ready is registered so it is low in
   // reset and never depends combinationally on consume_n.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_NORMAL;
         acc_q    <= '0;
         cnt_q    <= '0;
         rdy_q    <= 1'b0;
         mvalid_q <= 1'b0;
         mcode_q  <= '0;
         mrst_q   <= 1'b0;
         uerr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         rdy_q    <= (state_d != ST_HOLD) && (cnt_d <= CNT_W'(FILL_MAX));
         mvalid_q <= (state_d == ST_HOLD);
         if (marker_c) begin
            mcode_q <= rd_if.in_data;
            mrst_q  <= (rd_if.in_data[7:3] == 5'b11010);
         end
         if (underflow_c) uerr_q <= 1'b1;
      end
   end

   assign rd_if.in_ready      = rdy_q;
   assign rd_if.peek_bits     = acc_q[ACC_W-1 -: PEEK_W];
   assign rd_if.bits_avail    = cnt_q;
   assign rd_if.marker_valid  = mvalid_q;
   assign rd_if.marker_code   = mcode_q;
   assign rd_if.marker_is_rst = mrst_q;
   assign rd_if.underflow_err = uerr_q;
endmodule

// File: doc/jpeg_entropy_bitstream_reader.md
Name: jpeg_entropy_bitstream_reader

Overview:
- Decoder-side front end of the JPEG entropy path; the read-direction counterpart of the encoder's entropy-coded-segment writer.
- Accepts the compressed byte stream and removes stuffing: 0xFF 0x00 becomes data 0xFF, and fill 0xFF bytes are dropped.
- Detects markers and presents an MSB-first bit window with variable-length consume for the downstream Huffman decoder.

Parameters:
- ACC_W, 32, bit accumulator depth in bits (multiple of 8, >= PEEK_W+8).
- PEEK_W, 16, width of the peek window presented to the Huffman decoder.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  8  compressed stream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- peek_bits  out  PEEK_W  next stream bits; MSB = oldest bit; positions beyond bits_avail read 0.
- bits_avail  out  $clog2(ACC_W+1)  valid bits in the accumulator.
- consume_n  in  $clog2(PEEK_W+1)  bits to discard this cycle, 0..PEEK_W.
- sync_clear  in  1  discard all accumulated bits (restart-interval padding).
- marker_valid  out  1  marker detected; stream held.
- marker_code  out  8  second byte of the marker.
- marker_is_rst  out  1  marker_code in 0xD0..0xD7.
- marker_ack  in  1  release marker hold.
- underflow_err  out  1  sticky; set when consume_n > bits_avail.

Behaviour:
- Reset: all outputs 0; in_ready 0 during reset and 1 the first cycle after; accumulator empty; state NORMAL.
- States:
  - NORMAL: a byte != 0xFF is appended (8 bits). Byte 0xFF -> SAW_FF, nothing appended.
  - SAW_FF, next byte:
    - 0x00: append 0xFF, go to NORMAL.
    - 0xFF: fill byte, stay in SAW_FF, nothing appended.
    - any other byte: latch marker_code, go to HOLD, nothing appended.
  - HOLD: in_ready=0; marker_valid=1 and marker_is_rst valid from the cycle after the marker byte is accepted. marker_ack -> NORMAL; marker_valid is 0 the next cycle. marker_ack outside HOLD is ignored.
- in_ready = (state != HOLD) && (bits_avail <= ACC_W-8), computed from registered state and count. There is no combinational path from consume_n to in_ready.
- Latency: a data byte accepted in cycle t appears in peek_bits/bits_avail at t+1. Stuffed 0xFF appears the cycle after its 0x00 is accepted.
- Per-cycle update:
  - count_next = count - consume_n + (append ? 8 : 0).
  - The accumulator shifts left by consume_n; the appended byte lands immediately after the surviving bits.
  - Consume and append in the same cycle are both honoured.
- consume_n > bits_avail: the consume is ignored entirely (count unchanged) and underflow_err is set. It clears only on reset.
- sync_clear: count becomes 0 and accumulator bits are zeroed. It overrides a same-cycle consume. A same-cycle append still lands, so count_next = 8 if a byte was appended. FSM state is unaffected.
- During HOLD, bits already accumulated remain consumable; bits_avail drains normally.
- Reset asserted mid-operation: immediate return to reset values. A pending marker or a pending SAW_FF is lost.
- Widths: all count arithmetic is done at $clog2(ACC_W+1)+1 bits, so underflow is detected before truncation.

Test Plan:
- Bytes 0xA5, 0x3C, no consume -> bits_avail 16, peek_bits 0xA53C. Then consume_n=4 -> bits_avail 12, peek 0x53C0.
- Bytes 0x12, 0xFF, 0x00, 0x34 -> bits_avail 24 after the final byte; peek 0x12FF; after consume 8, peek 0xFF34. Stuffed 0x00 never appears.
- Bytes 0xFF, 0xFF, 0xD3 -> nothing appended; marker_valid=1, marker_code 0xD3, marker_is_rst=1, in_ready=0. marker_ack -> marker_valid 0 next cycle, in_ready 1.
- Fill accumulator to 32 bits -> in_ready=0. consume_n=8 in the same cycle as the next byte offered -> byte accepted one cycle later, bits_avail returns to 32.
- bits_avail=5, consume_n=6 -> bits_avail stays 5, underflow_err=1 and stays 1 until rst_n low.
- sync_clear with consume_n=3 and an appended byte 0x81 in the same cycle -> bits_avail 8, peek 0x8100. Async reset mid-SAW_FF -> all outputs 0; following byte 0x00 is appended as data 0x00.
